// File: rtl/bbox_pkg.sv
// Shared widths, sequencer state encoding and the result record used by the
// bounding-box frame sequencer.
package bbox_pkg;

    localparam int COORD_W = 11;
    localparam int AREA_W  = 22;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KICK,
        ST_WAIT_LOW,
        ST_WAIT_HIGH,
        ST_CALC,
        ST_PRESENT,
        ST_ABORT
    } seq_state_t;

    typedef struct packed {
        logic [COORD_W-1:0] x0;
        logic [COORD_W-1:0] y0;
        logic [COORD_W-1:0] w;
        logic [COORD_W-1:0] h;
        logic [COORD_W-1:0] cx;
        logic [COORD_W-1:0] cy;
        logic [AREA_W-1:0]  area;
        logic               found;
        logic               timeout;
    } bbox_res_t;

endpackage

// File: rtl/bbox_geom.sv
// Combinational geometry derivation from latched min/max extents.
// An inverted extent pair means the engine found no pixels.
module bbox_geom
    import bbox_pkg::*;
#(
    parameter int unsigned MIN_AREA = 4
) (
    input  logic [COORD_W-1:0] xmin,
    input  logic [COORD_W-1:0] xmax,
    input  logic [COORD_W-1:0] ymin,
    input  logic [COORD_W-1:0] ymax,
    output bbox_res_t          res
);

    logic               empty;
    logic [COORD_W:0]   xsum;
    logic [COORD_W:0]   ysum;
    logic [COORD_W-1:0] w;
    logic [COORD_W-1:0] h;
    logic [AREA_W-1:0]  area;

    always_comb begin
        empty = (xmin > xmax) || (ymin > ymax);
        w     = xmax - xmin + COORD_W'(1);
        h     = ymax - ymin + COORD_W'(1);
        area  = AREA_W'(w) * AREA_W'(h);
        // 12-bit sums keep the carry so the centre never wraps
        xsum  = {1'b0, xmin} + {1'b0, xmax};
        ysum  = {1'b0, ymin} + {1'b0, ymax};

        res = '0;
        if (!empty) begin
            res.x0    = xmin;
            res.y0    = ymin;
            res.w     = w;
            res.h     = h;
            res.cx    = COORD_W'(xsum >> 1);
            res.cy    = COORD_W'(ysum >> 1);
            res.area  = area;
            res.found = (area >= AREA_W'(MIN_AREA));
        end
    end

endmodule

// File: rtl/bbox_frame_sequencer.sv
// Frame-level controller for the boundingBox scan engine: kick, watchdog-guarded
// wait for done, geometry derivation and a valid/ready result port.
module bbox_frame_sequencer
    import bbox_pkg::*;
#(
    parameter int unsigned WIDTH          = 100,
    parameter int unsigned HEIGHT         = 100,
    parameter int unsigned MIN_AREA       = 4,
    parameter int unsigned TIMEOUT_CYCLES = 3 * WIDTH * HEIGHT + 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_req,
    output logic               frame_ack,
    output logic               bb_rst_n,
    output logic               bb_start,
    input  logic               bb_done,
    input  logic [COORD_W-1:0] bb_xmin,
    input  logic [COORD_W-1:0] bb_xmax,
    input  logic [COORD_W-1:0] bb_ymin,
    input  logic [COORD_W-1:0] bb_ymax,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [COORD_W-1:0] res_x0,
    output logic [COORD_W-1:0] res_y0,
    output logic [COORD_W-1:0] res_w,
    output logic [COORD_W-1:0] res_h,
    output logic [COORD_W-1:0] res_cx,
    output logic [COORD_W-1:0] res_cy,
    output logic [AREA_W-1:0]  res_area,
    output logic               res_found,
    output logic               res_timeout
);

    localparam int unsigned     WD_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);

    seq_state_t         state;
    seq_state_t         state_nxt;
    logic [WD_W-1:0]    wdog;
    logic               waiting;
    logic               wd_hit;
    logic [COORD_W-1:0] xmin_q;
    logic [COORD_W-1:0] xmax_q;
    logic [COORD_W-1:0] ymin_q;
    logic [COORD_W-1:0] ymax_q;
    bbox_res_t          geom_res;
    bbox_res_t          res_q;

    bbox_geom #(
        .MIN_AREA (MIN_AREA)
    ) u_geom (
        .xmin (xmin_q),
        .xmax (xmax_q),
        .ymin (ymin_q),
        .ymax (ymax_q),
        .res  (geom_res)
    );

    always_comb begin
        waiting = (state == ST_WAIT_LOW) || (state == ST_WAIT_HIGH);
        wd_hit  = (wdog == WD_LIMIT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            wdog   <= '0;
            xmin_q <= '0;
            xmax_q <= '0;
            ymin_q <= '0;
            ymax_q <= '0;
            res_q  <= '0;
        end else begin
            state <= state_nxt;

            if (state == ST_KICK)
                wdog <= '0;
            else if (waiting && !wd_hit)
                wdog <= wdog + 1'b1;

            if (state == ST_WAIT_HIGH && bb_done && !wd_hit) begin
                xmin_q <= bb_xmin;
                xmax_q <= bb_xmax;
                ymin_q <= bb_ymin;
                ymax_q <= bb_ymax;
            end

            if (state == ST_CALC)
                res_q <= geom_res;
            else if (state == ST_ABORT)
                res_q <= '{timeout: 1'b1, default: '0};
        end
    end

    // Watchdog expiry is tested before bb_done so a late done cannot mask an abort.
    always_comb begin
        state_nxt = state;
        frame_ack = 1'b0;
        bb_start  = 1'b0;
        bb_rst_n  = 1'b1;
        res_valid = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (frame_req)
                    state_nxt = ST_KICK;
            end
            ST_KICK: begin
                frame_ack = 1'b1;
                bb_start  = 1'b1;
                state_nxt = ST_WAIT_LOW;
            end
            ST_WAIT_LOW: begin
                if (wd_hit)
                    state_nxt = ST_ABORT;
                else if (!bb_done)
                    state_nxt = ST_WAIT_HIGH;
            end
            ST_WAIT_HIGH: begin
                if (wd_hit)
                    state_nxt = ST_ABORT;
                else if (bb_done)
                    state_nxt = ST_CALC;
            end
            ST_CALC: begin
                state_nxt = ST_PRESENT;
            end
            ST_PRESENT: begin
                res_valid = 1'b1;
                if (res_ready)
                    state_nxt = ST_IDLE;
            end
            ST_ABORT: begin
                bb_rst_n  = 1'b0;
                state_nxt = ST_PRESENT;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign res_x0      = res_q.x0;
    assign res_y0      = res_q.y0;
    assign res_w       = res_q.w;
    assign res_h       = res_q.h;
    assign res_cx      = res_q.cx;
    assign res_cy      = res_q.cy;
    assign res_area    = res_q.area;
    assign res_found   = res_q.found;
    assign res_timeout = res_q.timeout;

endmodule

// File: tb/tb_bbox_frame_sequencer.sv
// Randomised bench for bbox_frame_sequencer: behavioural engine + image model,
// per-cycle output checker and a few hand-computed pin cases.
module tb_bbox_frame_sequencer;

    localparam int W     = 8;
    localparam int H     = 8;
    localparam int MIN_A = 4;
    localparam int TMO   = 208;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        frame_req = 1'b0;
    logic        res_ready = 1'b0;
    logic        bb_done   = 1'b0;
    logic [10:0] bb_xmin   = '0;
    logic [10:0] bb_xmax   = '0;
    logic [10:0] bb_ymin   = '0;
    logic [10:0] bb_ymax   = '0;
    logic        frame_ack, bb_rst_n, bb_start, res_valid, res_found, res_timeout;
    logic [10:0] res_x0, res_y0, res_w, res_h, res_cx, res_cy;
    logic [21:0] res_area;

    bbox_frame_sequencer #(
        .WIDTH          (W),
        .HEIGHT         (H),
        .MIN_AREA       (MIN_A),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_req   (frame_req),
        .frame_ack   (frame_ack),
        .bb_rst_n    (bb_rst_n),
        .bb_start    (bb_start),
        .bb_done     (bb_done),
        .bb_xmin     (bb_xmin),
        .bb_xmax     (bb_xmax),
        .bb_ymin     (bb_ymin),
        .bb_ymax     (bb_ymax),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_x0      (res_x0),
        .res_y0      (res_y0),
        .res_w       (res_w),
        .res_h       (res_h),
        .res_cx      (res_cx),
        .res_cy      (res_cy),
        .res_area    (res_area),
        .res_found   (res_found),
        .res_timeout (res_timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // image: dark[x][y]
    bit dark [W][H];
    bit hang    = 1'b0;
    int eng_lat = 4;

    typedef struct {
        int x0, y0, w, h, cx, cy, area, found, tmo;
    } res_m_t;

    function automatic res_m_t model_result(input bit tmo);
        res_m_t r;
        int xl = W, xh = -1, yl = H, yh = -1;
        r = '{default: 0};
        if (tmo) begin
            r.tmo = 1;
            return r;
        end
        for (int x = 0; x < W; x++)
            for (int y = 0; y < H; y++)
                if (dark[x][y]) begin
                    if (x < xl) xl = x;
                    if (x > xh) xh = x;
                    if (y < yl) yl = y;
                    if (y > yh) yh = y;
                end
        if (xh >= 0) begin
            r.x0    = xl;
            r.y0    = yl;
            r.w     = xh - xl + 1;
            r.h     = yh - yl + 1;
            r.cx    = (xl + xh) / 2;
            r.cy    = (yl + yh) / 2;
            r.area  = r.w * r.h;
            r.found = (r.area >= MIN_A) ? 1 : 0;
        end
        return r;
    endfunction

    function automatic res_m_t dut_res();
        res_m_t r;
        r.x0 = int'(res_x0);  r.y0 = int'(res_y0);
        r.w  = int'(res_w);   r.h  = int'(res_h);
        r.cx = int'(res_cx);  r.cy = int'(res_cy);
        r.area  = int'(res_area);
        r.found = int'(res_found);
        r.tmo   = int'(res_timeout);
        return r;
    endfunction

    task automatic cmp_res(input string tag, input res_m_t a, input res_m_t e);
        check({tag, "_x0"}, a.x0, e.x0);     check({tag, "_y0"}, a.y0, e.y0);
        check({tag, "_w"}, a.w, e.w);        check({tag, "_h"}, a.h, e.h);
        check({tag, "_cx"}, a.cx, e.cx);     check({tag, "_cy"}, a.cy, e.cy);
        check({tag, "_area"}, a.area, e.area);
        check({tag, "_found"}, a.found, e.found);
        check({tag, "_timeout"}, a.tmo, e.tmo);
    endtask

    // ---- engine model + per-cycle checker, all on the falling edge ----
    int     cyc = 0, ack_cnt = 0, ack_cyc = 0, ev_cyc = 0;
    int     eng_stage = 0, eng_cnt = 0;
    bit     exp_set = 0, ev_tmo = 0;
    bit     valid_prev = 0, hs_prev = 0, rst_prev = 0, abort_prev = 0;
    res_m_t exp_r, prev_r;

    always @(negedge clk) begin
        res_m_t cur;
        int xl, xh, yl, yh;
        cyc++;
        cur = dut_res();

        if (rst_prev) begin
            check("rst_valid", res_valid, 0);
            check("rst_ack", frame_ack, 0);
            check("rst_start", bb_start, 0);
            check("rst_bb_rst_n", bb_rst_n, 1);
            check("rst_w", cur.w, 0);
            check("rst_area", cur.area, 0);
            check("rst_timeout", cur.tmo, 0);
        end
        check("start_vs_ack", bb_start, frame_ack);
        if (frame_ack) begin
            ack_cnt++;
            ack_cyc = cyc;
        end
        if (!bb_rst_n) begin
            check("abort_delay", cyc - ack_cyc, TMO + 1);
            check("abort_width", abort_prev, 0);
            exp_r   = model_result(1'b1);
            exp_set = 1;
            ev_cyc  = cyc;
            ev_tmo  = 1;
        end
        if (hs_prev)
            check("valid_drop_after_hs", res_valid, 0);
        if (res_valid) begin
            if (!exp_set)
                check("valid_without_run", res_valid, 0);
            else begin
                cmp_res("res", cur, exp_r);
                if (!valid_prev)
                    check("latency", cyc - ev_cyc, ev_tmo ? 1 : 2);
            end
            if (valid_prev && !hs_prev) begin
                check("stable_w", cur.w, prev_r.w);
                check("stable_area", cur.area, prev_r.area);
                check("stable_x0", cur.x0, prev_r.x0);
            end
            if (res_ready)
                exp_set = 0;
        end
        if (!rst_n)
            exp_set = 0;

        hs_prev    = res_valid && res_ready && rst_n;
        valid_prev = res_valid && rst_n;
        prev_r     = cur;
        rst_prev   = !rst_n;
        abort_prev = !bb_rst_n;

        // engine: done drops two cycles after start is seen, rises eng_lat later
        if (!rst_n || !bb_rst_n) begin
            bb_done   = 1'b0;
            eng_stage = 0;
        end else begin
            case (eng_stage)
                0: if (bb_start) eng_stage = 1;
                1: eng_stage = 2;
                2: begin
                    bb_done   = 1'b0;
                    eng_cnt   = eng_lat;
                    eng_stage = 3;
                end
                default: if (!hang) begin
                    eng_cnt--;
                    if (eng_cnt <= 0) begin
                        xl = W; xh = 0; yl = H; yh = 0;
                        for (int x = 0; x < W; x++)
                            for (int y = 0; y < H; y++)
                                if (dark[x][y]) begin
                                    if (x < xl) xl = x;
                                    if (x > xh) xh = x;
                                    if (y < yl) yl = y;
                                    if (y > yh) yh = y;
                                end
                        bb_xmin   = 11'(xl);
                        bb_xmax   = 11'(xh);
                        bb_ymin   = 11'(yl);
                        bb_ymax   = 11'(yh);
                        bb_done   = 1'b1;
                        eng_stage = 0;
                        exp_r     = model_result(1'b0);
                        exp_set   = 1;
                        ev_cyc    = cyc;
                        ev_tmo    = 0;
                    end
                end
            endcase
        end
    end

    // ---- stimulus ----
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_img();
        for (int x = 0; x < W; x++)
            for (int y = 0; y < H; y++)
                dark[x][y] = 1'b0;
    endtask

    task automatic rect(input int x0, input int x1, input int y0, input int y1);
        for (int x = x0; x <= x1; x++)
            for (int y = y0; y <= y1; y++)
                dark[x][y] = 1'b1;
    endtask

    task automatic wait_ack(input string tag);
        int n = 0;
        while (!frame_ack && n < 20) begin tick(); n++; end
        check({tag, "_ack_seen"}, frame_ack, 1);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!res_valid && n < 400) begin tick(); n++; end
        check({tag, "_valid_seen"}, res_valid, 1);
    endtask

    task automatic run_frame(input bit hold, input int ready_delay, input bit early,
                             output res_m_t got);
        frame_req = 1'b1;
        if (early) res_ready = 1'b1;
        wait_ack("run");
        if (!hold) frame_req = 1'b0;
        wait_valid("run");
        repeat (ready_delay) tick();
        res_ready = 1'b1;
        got = dut_res();
        tick();
        res_ready = 1'b0;
        frame_req = 1'b0;
    endtask

    initial begin
        res_m_t got, got1, m;
        int a0, px, py, xa, xb, ya, yb;
        bit early;

        clear_img();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // single dark pixel: below MIN_AREA
        clear_img();
        dark[3][5] = 1'b1;
        m = model_result(1'b0);
        check("model_px_area", m.area, 1);
        run_frame(0, 2, 0, got);
        check("px_x0", got.x0, 3);   check("px_y0", got.y0, 5);
        check("px_w", got.w, 1);     check("px_h", got.h, 1);
        check("px_cx", got.cx, 3);   check("px_cy", got.cy, 5);
        check("px_area", got.area, 1);
        check("px_found", got.found, 0);
        check("px_timeout", got.tmo, 0);

        // rectangle x 2..5, y 1..6
        clear_img();
        rect(2, 5, 1, 6);
        m = model_result(1'b0);
        check("model_rect_area", m.area, 24);
        run_frame(0, 0, 0, got);
        check("rect_w", got.w, 4);   check("rect_h", got.h, 6);
        check("rect_cx", got.cx, 3); check("rect_cy", got.cy, 3);
        check("rect_area", got.area, 24);
        check("rect_found", got.found, 1);

        // all-white frame
        clear_img();
        run_frame(1, 1, 0, got);
        check("white_w", got.w, 0);  check("white_x0", got.x0, 0);
        check("white_area", got.area, 0);
        check("white_found", got.found, 0);
        check("white_timeout", got.tmo, 0);

        // request held high with backpressure: one ack, then an identical second run
        clear_img();
        rect(1, 6, 2, 3);
        eng_lat   = 4;
        a0        = ack_cnt;
        frame_req = 1'b1;
        wait_valid("held1");
        repeat (50) tick();
        check("held_one_ack", ack_cnt - a0, 1);
        got1      = dut_res();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        tick();
        wait_valid("held2");
        check("held_two_acks", ack_cnt - a0, 2);
        got = dut_res();
        check("held_same_w", got.w, got1.w);
        check("held_same_area", got.area, got1.area);
        check("held_w", got.w, 6);
        check("held_h", got.h, 2);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        frame_req = 1'b0;
        tick();

        // engine that never finishes
        hang = 1'b1;
        run_frame(0, 3, 0, got);
        hang = 1'b0;
        check("tmo_timeout", got.tmo, 1);
        check("tmo_w", got.w, 0);    check("tmo_x0", got.x0, 0);
        check("tmo_area", got.area, 0);
        check("tmo_found", got.found, 0);

        // reset while waiting for done
        clear_img();
        dark[4][4] = 1'b1;
        eng_lat    = 30;
        frame_req  = 1'b1;
        wait_ack("rstwh");
        frame_req = 1'b0;
        repeat (8) tick();
        rst_n = 1'b0;
        tick();
        check("rstwh_valid", res_valid, 0);
        check("rstwh_ack", frame_ack, 0);
        rst_n = 1'b1;
        tick();
        eng_lat = 3;
        run_frame(0, 0, 0, got);
        check("after_rstwh_cx", got.cx, 4);
        check("after_rstwh_w", got.w, 1);

        // reset while a result is pending
        clear_img();
        rect(0, 7, 0, 7);
        frame_req = 1'b1;
        wait_valid("rstpr");
        tick();
        rst_n = 1'b0;
        tick();
        check("rstpr_valid", res_valid, 0);
        check("rstpr_ack", frame_ack, 0);
        rst_n     = 1'b1;
        frame_req = 1'b0;
        tick();
        run_frame(0, 1, 0, got);
        check("after_rstpr_area", got.area, 64);
        check("after_rstpr_cx", got.cx, 3);

        // randomised frames
        for (int i = 0; i < 30; i++) begin
            clear_img();
            case ($urandom_range(0, 3))
                0: ;
                1: begin
                    px = $urandom_range(0, W - 1);
                    py = $urandom_range(0, H - 1);
                    dark[px][py] = 1'b1;
                end
                2: begin
                    xa = $urandom_range(0, W - 1); xb = $urandom_range(xa, W - 1);
                    ya = $urandom_range(0, H - 1); yb = $urandom_range(ya, H - 1);
                    rect(xa, xb, ya, yb);
                end
                default: begin
                    for (int x = 0; x < W; x++)
                        for (int y = 0; y < H; y++)
                            dark[x][y] = ($urandom_range(0, 7) == 0);
                end
            endcase
            eng_lat = $urandom_range(1, 25);
            early   = ($urandom_range(0, 3) == 0);
            run_frame(1'($urandom_range(0, 1)), early ? 0 : $urandom_range(0, 8), early, got);
            m = model_result(1'b0);
            check("rand_w", got.w, m.w);
            check("rand_area", got.area, m.area);
            check("rand_found", got.found, m.found);
            repeat ($urandom_range(0, 3)) tick();
        end

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL global_timeout: simulation did not complete");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
